apb_master: RTL and testbench



---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_master.sv | 117 +++++++++++
 tb/tb_apb_master.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM states, default bus widths and the
// response bundle returned to the command-port consumer.
package apb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master.sv
// APB requester: one command at a time through SETUP/ACCESS, with a bounded
// wait counter that aborts transfers whose peripheral never raises pready.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic              psel,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  apb_state_t       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt, cnt_d;
  logic             run_q;
  logic             accept;
  logic             done;
  logic             timed_out;

  // run_q keeps cmd_ready low until the first edge after reset release.
  assign cmd_ready = (state_q == IDLE) && presetn && run_q;
  assign accept    = cmd_valid && cmd_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = wait_cnt;
    done      = 1'b0;
    timed_out = 1'b0;
    unique case (state_q)
      IDLE:   if (accept) state_d = SETUP;
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          done    = 1'b1;
          state_d = RESP;
        end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
          done      = 1'b1;
          timed_out = 1'b1;
          state_d   = RESP;
        end else if (wait_cnt != '1) begin
          cnt_d = wait_cnt + CNT_W'(1);
        end
      end
      RESP:   if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= IDLE;
      wait_cnt <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= cnt_d;
      run_q    <= 1'b1;
    end
  end

  // Bus and response outputs are registered from the next state.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      psel        <= 1'b0;
      penable     <= 1'b0;
      rsp_valid   <= 1'b0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      psel      <= (state_d == SETUP) || (state_d == ACCESS);
      penable   <= (state_d == ACCESS);
      rsp_valid <= (state_d == RESP);
      if (accept) begin
        paddr  <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_wdata;
      end
      if (done) begin
        rsp_rdata   <= (timed_out || pwrite) ? '0 : prdata;
        rsp_err     <= timed_out || pslverr;
        rsp_timeout <= timed_out;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master against a 16-byte APB memory model with
// programmable wait states; expected responses flow through a scoreboard queue.
module tb_apb_master;
  import apb_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int HANG    = 1000;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic [31:0] paddr;
  logic        pwrite, psel, penable;
  logic [7:0]  pwdata, prdata;
  logic        pready, pslverr;

  int          n_checks = 0;
  int          n_errors = 0;
  int          wait_cfg = 0;
  int          acc_cnt  = 0;
  logic [7:0]  mem     [16] = '{default: 8'h00};
  logic [7:0]  ref_mem [16] = '{default: 8'h00};
  apb_rsp_t    exp_q[$];

  apb_master #(.ADDR_W(32), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // Peripheral model: pready after wait_cfg wait states; pslverr for addresses
  // beyond the memory, and also toggled high during wait states where it must be ignored.
  assign pready  = psel && penable && (acc_cnt == wait_cfg);
  assign pslverr = psel && penable && ((paddr >= 32'd16) || !pready);
  assign prdata  = (paddr < 32'd16) ? mem[paddr[3:0]] : 8'hEE;

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (psel && penable && pready && pwrite && (paddr < 32'd16)) mem[paddr[3:0]] <= pwdata;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Presents a command and waits (bounded) for it to be accepted.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [7:0] wd,
                       output bit ok);
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      else @(negedge pclk);
    end
    if (!ok) check("accept_bound", 32'd0, 32'd1);
    @(negedge pclk);
    cmd_valid = 1'b0;
    cmd_addr  = addr ^ 32'h0000_000F;
    cmd_wdata = ~wd;
  endtask

  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] wd,
                         input int hold);
    apb_rsp_t e, got, popped;
    int       lat, exp_lat, psel_n, pen_n, bad;
    bit       ok;
    if (wait_cfg >= TIMEOUT) begin
      e = '{rdata: 8'h00, err: 1'b1, timeout: 1'b1};
    end else if (addr >= 32'd16) begin
      e = '{rdata: (wr ? 8'h00 : 8'hEE), err: 1'b1, timeout: 1'b0};
    end else if (wr) begin
      e = '{rdata: 8'h00, err: 1'b0, timeout: 1'b0};
      ref_mem[addr[3:0]] = wd;
    end else begin
      e = '{rdata: ref_mem[addr[3:0]], err: 1'b0, timeout: 1'b0};
    end
    exp_lat = (wait_cfg >= TIMEOUT) ? TIMEOUT + 2 : 3 + wait_cfg;
    exp_q.push_back(e);
    issue(wr, addr, wd, ok);
    if (!ok) begin
      void'(exp_q.pop_back());
      return;
    end
    lat = 1; psel_n = 0; pen_n = 0; bad = 0;
    while (!rsp_valid && lat < 100) begin
      if (psel) psel_n++;
      if (penable) pen_n++;
      if (psel && (paddr !== addr || pwrite !== wr || pwdata !== wd)) bad++;
      @(negedge pclk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("psel_cycles", 32'(psel_n), 32'(exp_lat - 1));
    check("penable_cycles", 32'(pen_n), 32'(exp_lat - 2));
    check("apb_stable", 32'(bad), 32'd0);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_fields", 32'({rsp_rdata, rsp_err, rsp_timeout}), 32'(e));
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      check("hold_no_apb", 32'({psel, penable}), 32'd0);
      @(negedge pclk);
    end
    got = '{rdata: rsp_rdata, err: rsp_err, timeout: rsp_timeout};
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    popped = exp_q.pop_front();
    check("rsp_rdata", 32'(got.rdata), 32'(popped.rdata));
    check("rsp_err", 32'(got.err), 32'(popped.err));
    check("rsp_timeout", 32'(got.timeout), 32'(popped.timeout));
    check("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    bit ok;
    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge pclk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_bus", 32'({psel, penable, pwrite}), 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata}), 32'd0);
    check("rst_paddr", paddr, 32'd0);
    presetn = 1'b1;
    #1 check("ready_before_edge", 32'(cmd_ready), 32'd0);
    @(negedge pclk);
    check("ready_after_edge", 32'(cmd_ready), 32'd1);

    wait_cfg = 0;
    run_cmd(1'b1, 32'd3, 8'hA5, 0);
    run_cmd(1'b0, 32'd3, 8'h00, 0);
    run_cmd(1'b0, 32'd20, 8'h11, 0);
    run_cmd(1'b1, 32'd21, 8'h22, 0);

    wait_cfg = 3;
    run_cmd(1'b1, 32'd7, 8'h3C, 0);
    run_cmd(1'b0, 32'd7, 8'h00, 0);

    wait_cfg = HANG;
    run_cmd(1'b0, 32'd3, 8'h00, 0);
    wait_cfg = TIMEOUT - 1;
    run_cmd(1'b0, 32'd3, 8'h00, 0);

    wait_cfg = 0;
    run_cmd(1'b0, 32'd7, 8'h00, 5);

    // Reset pulse in the middle of a stalled ACCESS phase.
    wait_cfg = HANG;
    issue(1'b0, 32'd3, 8'h00, ok);
    repeat (2) @(negedge pclk);
    check("pre_rst_access", 32'({psel, penable}), 32'd3);
    #2 presetn = 1'b0;
    #1;
    check("rst_async_bus", 32'({psel, penable}), 32'd0);
    check("rst_async_ready", 32'(cmd_ready), 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    wait_cfg = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      check("post_rst_idle", 32'({psel, cmd_ready}), 32'd1);
    end
    run_cmd(1'b1, 32'd9, 8'h5A, 0);
    run_cmd(1'b0, 32'd9, 8'h00, 0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
